// File: rtl/lpddr4_ctrl_pkg.sv
// lpddr4_ctrl_pkg: shared types and default widths for the LPDDR4 controller command path.
//   AW_DEF / BAW_DEF : default command and bank address widths
//   arb_state_e      : command arbiter states
//   cmd_payload_t    : one controller command as carried on the command port
package lpddr4_ctrl_pkg;
  localparam int AW_DEF = 17;
  localparam int BAW_DEF = 3;
  typedef enum logic [1:0] {ARB, DRAIN, REFRESH} arb_state_e;
  typedef struct packed {
    logic [AW_DEF-1:0] a;
    logic [BAW_DEF-1:0] ba;
    logic cas;
    logic ras;
    logic we;
    logic is_cmd;
    logic is_read;
    logic is_write;
  } cmd_payload_t;
endpackage

// File: rtl/lpddr4_cmd_arbiter_rr_picker.sv
// rr_picker: N-wide rotating priority encoder; the first set req bit at or above ptr (wrapping) wins.
//   req   : request vector
//   ptr   : highest-priority index
//   grant : one-hot winner (all zero when no request)
//   idx   : winner index
//   any   : at least one request present
module rr_picker #(
  parameter int N = 8,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    // Scan from the farthest offset down so the closest requester after ptr is written last.
    for (int k = N - 1; k >= 0; k--)
      if (req[IW'((int'(ptr) + k) % N)]) idx = IW'((int'(ptr) + k) % N);
    any = |req;
    grant = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/lpddr4_cmd_arbiter.sv
// lpddr4_cmd_arbiter: round-robin arbiter from NREQ bank machines onto one registered command port, with drained exclusive refresh grant.
//   clk, rst (async, active-high)
//   req_valid/req_ready + per-bank payload slices (req_a[i*AW +: AW], req_ba[i*BAW +: BAW], command bits, class bits)
//   cmd_valid/cmd_ready + cmd_payload_* : registered output command
//   refresh_req / refresh_gnt           : refresher handshake, grant only once the port is empty
// Optional: define LPDDR4_CMD_ARB_RW_GROUP_EN to group reads/writes and enforce TURNAROUND idle cycles between directions.
module lpddr4_cmd_arbiter
  import lpddr4_ctrl_pkg::*;
#(
  parameter int NREQ = 8,
  parameter int AW = AW_DEF,
  parameter int BAW = BAW_DEF,
  parameter int TURNAROUND = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*AW-1:0]  req_a,
  input  logic [NREQ*BAW-1:0] req_ba,
  input  logic [NREQ-1:0]     req_cas,
  input  logic [NREQ-1:0]     req_ras,
  input  logic [NREQ-1:0]     req_we,
  input  logic [NREQ-1:0]     req_is_cmd,
  input  logic [NREQ-1:0]     req_is_read,
  input  logic [NREQ-1:0]     req_is_write,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [AW-1:0]     cmd_payload_a,
  output logic [BAW-1:0]    cmd_payload_ba,
  output logic              cmd_payload_cas,
  output logic              cmd_payload_ras,
  output logic              cmd_payload_we,
  output logic              cmd_payload_is_cmd,
  output logic              cmd_payload_is_read,
  output logic              cmd_payload_is_write,
  input  logic              refresh_req,
  output logic              refresh_gnt
);
  localparam int IW = $clog2(NREQ);
  // The payload register is the package struct, so widths must match its defaults.
  if (AW != AW_DEF || BAW != BAW_DEF || NREQ < 2 || NREQ > 8 || TURNAROUND < 0) begin : g_bad_cfg
    $error("lpddr4_cmd_arbiter: unsupported parameter set");
  end
  arb_state_e state, nxt;
  cmd_payload_t pay_q, pick;
  logic [IW-1:0] rr_ptr, idx;
  logic [NREQ-1:0] eligible, grant;
  logic any, accept;
`ifdef LPDDR4_CMD_ARB_RW_GROUP_EN
  localparam int TW = TURNAROUND > 0 ? $clog2(TURNAROUND + 1) : 1;
  logic last_dir;
  logic [TW-1:0] ta_cnt;
  logic [NREQ-1:0] same_cas, opp_cas;
  logic hold_opp;
  always_comb begin
    same_cas = req_valid & (last_dir ? req_is_write : req_is_read);
    opp_cas = req_valid & (last_dir ? req_is_read : req_is_write);
    hold_opp = |same_cas | |(req_valid & req_is_cmd) | (ta_cnt != '0);
    eligible = req_valid & ~(opp_cas & {NREQ{hold_opp}});
  end
  // Every CAS restarts the gap, so a direction change always sees TURNAROUND cycles since the last CAS.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_dir <= 1'b0;
      ta_cnt <= '0;
    end else if (accept & (pick.is_read | pick.is_write)) begin
      last_dir <= pick.is_write;
      ta_cnt <= TW'(TURNAROUND);
    end else if (ta_cnt != '0) begin
      ta_cnt <= ta_cnt - 1'b1;
    end
`else
  assign eligible = req_valid;
`endif
  rr_picker #(.N(NREQ)) u_pick (
    .req(eligible),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(idx),
    .any(any)
  );
  always_comb begin
    pick.a = req_a[int'(idx) * AW +: AW];
    pick.ba = req_ba[int'(idx) * BAW +: BAW];
    pick.cas = req_cas[idx];
    pick.ras = req_ras[idx];
    pick.we = req_we[idx];
    pick.is_cmd = req_is_cmd[idx];
    pick.is_read = req_is_read[idx];
    pick.is_write = req_is_write[idx];
    accept = ~rst & (state == ARB) & ~refresh_req & (~cmd_valid | cmd_ready) & any;
    req_ready = accept ? grant : '0;
    // A falling refresh_req wins over drain completion, so DRAIN can exit without a grant.
    nxt = state == ARB ? (refresh_req ? DRAIN : ARB)
        : ~refresh_req ? ARB
        : (state == REFRESH || ~cmd_valid || cmd_ready) ? REFRESH : DRAIN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ARB;
      refresh_gnt <= 1'b0;
      cmd_valid <= 1'b0;
      rr_ptr <= '0;
      pay_q <= '0;
    end else begin
      state <= nxt;
      refresh_gnt <= nxt == REFRESH;
      cmd_valid <= accept | (cmd_valid & ~cmd_ready);
      if (accept) begin
        pay_q <= pick;
        rr_ptr <= idx == IW'(NREQ - 1) ? '0 : idx + 1'b1;
      end
    end
  assign cmd_payload_a = pay_q.a;
  assign cmd_payload_ba = pay_q.ba;
  assign cmd_payload_cas = pay_q.cas;
  assign cmd_payload_ras = pay_q.ras;
  assign cmd_payload_we = pay_q.we;
  assign cmd_payload_is_cmd = pay_q.is_cmd;
  assign cmd_payload_is_read = pay_q.is_read;
  assign cmd_payload_is_write = pay_q.is_write;
endmodule

// File: tb/tb_lpddr4_cmd_arbiter.sv
// tb_lpddr4_cmd_arbiter: self-checking bench for lpddr4_cmd_arbiter against a behavioural port model.
module tb_lpddr4_cmd_arbiter;
  localparam int N = 8;
  localparam int AW = 17;
  localparam int BAW = 3;
  localparam int PW = AW + BAW + 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_ready, req_cas = '0, req_ras = '0, req_we = '0;
  logic [N-1:0] req_is_cmd = '0, req_is_read = '0, req_is_write = '0;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BAW-1:0] req_ba = '0;
  logic cmd_valid, cmd_ready = 1'b0, refresh_req = 1'b0, refresh_gnt;
  logic [AW-1:0] cmd_payload_a;
  logic [BAW-1:0] cmd_payload_ba;
  logic cmd_payload_cas, cmd_payload_ras, cmd_payload_we;
  logic cmd_payload_is_cmd, cmd_payload_is_read, cmd_payload_is_write;
  logic [PW-1:0] dut_pay;
  assign dut_pay = {cmd_payload_a, cmd_payload_ba, cmd_payload_cas, cmd_payload_ras, cmd_payload_we,
                    cmd_payload_is_cmd, cmd_payload_is_read, cmd_payload_is_write};
  lpddr4_cmd_arbiter #(.NREQ(N), .AW(AW), .BAW(BAW), .TURNAROUND(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_ba(req_ba),
    .req_cas(req_cas), .req_ras(req_ras), .req_we(req_we),
    .req_is_cmd(req_is_cmd), .req_is_read(req_is_read), .req_is_write(req_is_write),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_a(cmd_payload_a), .cmd_payload_ba(cmd_payload_ba),
    .cmd_payload_cas(cmd_payload_cas), .cmd_payload_ras(cmd_payload_ras), .cmd_payload_we(cmd_payload_we),
    .cmd_payload_is_cmd(cmd_payload_is_cmd), .cmd_payload_is_read(cmd_payload_is_read),
    .cmd_payload_is_write(cmd_payload_is_write),
    .refresh_req(refresh_req), .refresh_gnt(refresh_gnt)
  );
  int errors = 0;
  int checks = 0;
  // Port model: mode 0 = granting banks, 1 = draining, 2 = refresh granted.
  bit m_valid, m_gnt, m_acc;
  logic [PW-1:0] m_pay;
  int m_ptr, m_mode, m_win;
  logic [N-1:0] exp_ready, obs_ready;
  function automatic logic [PW-1:0] pay_of(int i);
    return {req_a[i*AW +: AW], req_ba[i*BAW +: BAW], req_cas[i], req_ras[i], req_we[i],
            req_is_cmd[i], req_is_read[i], req_is_write[i]};
  endfunction
  task automatic model_reset();
    m_valid = 0;
    m_gnt = 0;
    m_pay = '0;
    m_ptr = 0;
    m_mode = 0;
  endtask
  task automatic model_comb();
    m_win = -1;
    for (int k = 0; k < N; k++)
      if (m_win < 0 && req_valid[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
    m_acc = !rst && m_mode == 0 && !refresh_req && (!m_valid || cmd_ready) && m_win >= 0;
    exp_ready = m_acc ? N'(1) << m_win : '0;
  endtask
  task automatic model_edge();
    bit port_busy;
    port_busy = m_valid && !cmd_ready;
    if (m_acc) begin
      m_pay = pay_of(m_win);
      m_valid = 1;
      m_ptr = (m_win + 1) % N;
    end else if (cmd_ready) begin
      m_valid = 0;
    end
    if (m_mode == 0) m_mode = refresh_req ? 1 : 0;
    else if (!refresh_req) m_mode = 0;
    else if (!port_busy) m_mode = 2;
    m_gnt = m_mode == 2;
  endtask
  // One clock: sample req_ready mid-cycle, advance the model at the edge, settle outputs.
  task automatic cycle();
    @(negedge clk);
    model_comb();
    obs_ready = req_ready;
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic rand_pay();
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = AW'($urandom);
      req_ba[i*BAW +: BAW] = BAW'($urandom);
    end
    req_cas = N'($urandom);
    req_ras = N'($urandom);
    req_we = N'($urandom);
    req_is_cmd = N'($urandom);
`ifdef LPDDR4_CMD_ARB_RW_GROUP_EN
    req_is_read = '0;
    req_is_write = '0;
`else
    req_is_read = N'($urandom);
    req_is_write = N'($urandom);
`endif
  endtask
  task automatic test_reset();
    req_valid = '1;
    model_reset();
    #1;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++;
    if (cmd_valid !== 1'b0 || refresh_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: cmd_valid=%b refresh_gnt=%b want 0 0", cmd_valid, refresh_gnt);
    end
    checks++;
    if (dut_pay !== '0) begin errors++; $display("FAIL reset_payload: got %h want 0", dut_pay); end
    req_valid = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask
  task automatic test_round_robin();
    int ord[6] = '{0, 3, 5, 0, 3, 5};
    logic [N-1:0] e;
    rand_pay();
    req_valid = 8'b0010_1001;
    cmd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      e = N'(1) << ord[k];
      checks++;
      if (obs_ready !== e) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, obs_ready, e); end
      checks++;
      if (cmd_valid !== 1'b1 || dut_pay !== pay_of(ord[k])) begin
        errors++; $display("FAIL rr_output[%0d]: valid=%b pay=%h want 1 %h", k, cmd_valid, dut_pay, pay_of(ord[k]));
      end
    end
  endtask
  task automatic test_stall();
    logic [PW-1:0] held;
    cycle();
    checks++;
    if (obs_ready !== 8'b0000_0001) begin errors++; $display("FAIL stall_wrap: got %b want 00000001", obs_ready); end
    held = pay_of(0);
    cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (obs_ready !== '0 || cmd_valid !== 1'b1 || dut_pay !== held) begin
        errors++; $display("FAIL stall_hold[%0d]: ready=%b valid=%b pay=%h want 0 1 %h", k, obs_ready, cmd_valid, dut_pay, held);
      end
    end
    cmd_ready = 1'b1;
    cycle();
    checks++;
    if (obs_ready !== 8'b0000_1000 || dut_pay !== pay_of(3)) begin
      errors++; $display("FAIL stall_resume: ready=%b pay=%h want 00001000 %h", obs_ready, dut_pay, pay_of(3));
    end
  endtask
  task automatic test_refresh_drain();
    cmd_ready = 1'b0;
    refresh_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (obs_ready !== '0 || refresh_gnt !== 1'b0 || cmd_valid !== 1'b1) begin
        errors++; $display("FAIL drain_wait[%0d]: ready=%b gnt=%b valid=%b want 0 0 1", k, obs_ready, refresh_gnt, cmd_valid);
      end
    end
    cmd_ready = 1'b1;
    cycle();
    checks++;
    if (refresh_gnt !== 1'b1 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL drain_done: gnt=%b valid=%b want 1 0", refresh_gnt, cmd_valid);
    end
    cycle();
    checks++;
    if (obs_ready !== '0 || refresh_gnt !== 1'b1) begin
      errors++; $display("FAIL refresh_hold: ready=%b gnt=%b want 0 1", obs_ready, refresh_gnt);
    end
    refresh_req = 1'b0;
    cycle();
    checks++;
    if (refresh_gnt !== 1'b0 || obs_ready !== '0) begin
      errors++; $display("FAIL refresh_release: gnt=%b ready=%b want 0 0", refresh_gnt, obs_ready);
    end
    cycle();
    checks++;
    if (obs_ready !== exp_ready || obs_ready === '0) begin
      errors++; $display("FAIL refresh_resume: ready=%b want %b", obs_ready, exp_ready);
    end
  endtask
  task automatic test_refresh_pulse();
    cmd_ready = 1'b0;
    refresh_req = 1'b1;
    cycle();
    refresh_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (refresh_gnt !== 1'b0 || obs_ready !== exp_ready || cmd_valid !== m_valid) begin
        errors++; $display("FAIL pulse[%0d]: gnt=%b ready=%b valid=%b want 0 %b %b", k, refresh_gnt, obs_ready, cmd_valid, exp_ready, m_valid);
      end
    end
    cmd_ready = 1'b1;
    cycle();
    checks++;
    if (obs_ready !== exp_ready || obs_ready === '0 || refresh_gnt !== 1'b0) begin
      errors++; $display("FAIL pulse_resume: ready=%b gnt=%b want %b 0", obs_ready, refresh_gnt, exp_ready);
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rand_pay();
      req_valid = $urandom_range(0, 3) == 0 ? '0 : N'($urandom);
      cmd_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) refresh_req = ~refresh_req;
      cycle();
      checks++;
      if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", k, obs_ready, exp_ready); end
      checks++;
      if (cmd_valid !== m_valid || dut_pay !== m_pay) begin
        errors++; $display("FAIL rand_out[%0d]: valid=%b pay=%h want %b %h", k, cmd_valid, dut_pay, m_valid, m_pay);
      end
      checks++;
      if (refresh_gnt !== m_gnt) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", k, refresh_gnt, m_gnt); end
    end
    refresh_req = 1'b0;
  endtask
`ifdef LPDDR4_CMD_ARB_RW_GROUP_EN
  task automatic test_turnaround();
    int t_wr = -1, t_rd = -1, t_cmd = -1;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    rand_pay();
    req_cas = '0; req_ras = '0; req_we = '0; req_is_cmd = '0;
    req_is_write[1] = 1'b1; req_cas[1] = 1'b1; req_we[1] = 1'b1;
    req_is_read[2] = 1'b1; req_cas[2] = 1'b1;
    req_is_cmd[4] = 1'b1; req_ras[4] = 1'b1;
    cmd_ready = 1'b1;
    refresh_req = 1'b0;
    req_valid = 8'b0000_0010;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (obs_ready[1]) req_valid = 8'b0001_0100;
      if (obs_ready[2]) req_valid[2] = 1'b0;
      if (obs_ready[4]) req_valid[4] = 1'b0;
      if (cmd_valid && cmd_payload_is_write && t_wr < 0) t_wr = t;
      if (cmd_valid && cmd_payload_is_read && t_rd < 0) t_rd = t;
      if (cmd_valid && cmd_payload_is_cmd && t_cmd < 0) t_cmd = t;
    end
    checks++;
    if (t_wr < 0 || t_rd < 0 || t_rd - t_wr < 5) begin
      errors++; $display("FAIL turnaround_gap: write at %0d read at %0d, want read >= write+5", t_wr, t_rd);
    end
    checks++;
    if (t_cmd <= t_wr || t_cmd >= t_rd) begin
      errors++; $display("FAIL turnaround_cmd: cmd at %0d, want between %0d and %0d", t_cmd, t_wr, t_rd);
    end
    req_valid = '0;
  endtask
`endif
  task automatic test_async_reset();
    rand_pay();
    req_valid = 8'b1111_0000;
    cmd_ready = 1'b1;
    refresh_req = 1'b0;
    repeat (2) cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || req_ready !== '0 || dut_pay !== '0) begin
      errors++; $display("FAIL async_rst_stream: valid=%b ready=%b pay=%h want 0 0 0", cmd_valid, req_ready, dut_pay);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    req_valid = '0;
    refresh_req = 1'b1;
    repeat (3) cycle();
    checks++;
    if (refresh_gnt !== 1'b1) begin errors++; $display("FAIL async_rst_setup: gnt=%b want 1", refresh_gnt); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (refresh_gnt !== 1'b0) begin errors++; $display("FAIL async_rst_gnt: gnt=%b want 0", refresh_gnt); end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    refresh_req = 1'b0;
    req_valid = 8'b0100_0100;
    cycle();
    checks++;
    if (obs_ready !== 8'b0000_0100 || dut_pay !== pay_of(2) || cmd_valid !== 1'b1) begin
      errors++; $display("FAIL async_rst_first: ready=%b valid=%b pay=%h want 00000100 1 %h", obs_ready, cmd_valid, dut_pay, pay_of(2));
    end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_refresh_drain();
    test_refresh_pulse();
    test_random();
`ifdef LPDDR4_CMD_ARB_RW_GROUP_EN
    test_turnaround();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
